// File: rtl/w5500_spi_ctrl.sv
// W5500 SPI master: hardware reset, network/socket-0 init, then single-byte
// register read/write service for the host logic.
// Optional build macro W5500_VERSION_CHECK_EN: read VERSIONR after init and
// flag o_init_err (holding in ERR) unless it returns 0x04.
module w5500_spi_ctrl #(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned RST_LOW_CYC  = 25000,
    parameter int unsigned RST_WAIT_CYC = 100000,
    parameter logic [31:0] GATEWAY_IP   = 32'hC0A8_0001,
    parameter logic [31:0] SUBNET_MASK  = 32'hFFFF_FF00,
    parameter logic [47:0] MAC_ADDR     = 48'h00_08_DC_01_02_03,
    parameter logic [31:0] LOCAL_IP     = 32'hC0A8_000A,
    parameter logic [15:0] SRC_PORT     = 16'd2112
) (
    input  logic        i_clk_50m,
    input  logic        i_rst_n,
    output logic        o_spi_cs,
    output logic        o_spi_dclk,
    output logic        o_spi_mosi,
    input  logic        i_spi_miso,
    output logic        o_w5500_rst,
    input  logic        i_cmd_valid,
    input  logic        i_cmd_wr,
    input  logic [4:0]  i_cmd_bsb,
    input  logic [15:0] i_cmd_addr,
    input  logic [7:0]  i_cmd_wdata,
    output logic        o_cmd_ready,
    output logic        o_rd_valid,
    output logic [7:0]  o_rd_data,
    output logic        o_init_done,
    output logic        o_init_err
);

    localparam int unsigned CNT_MAX   = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned DIV_W     = $clog2(CLK_DIV + 1);
    localparam int unsigned HP_W      = 7;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned INIT_LEN  = 22;
    localparam int unsigned NET_BYTES = 18;
    // Common-register identity bytes, laid out in address order 0x0001..0x0012
    localparam logic [143:0] NET_ID = {GATEWAY_IP, SUBNET_MASK, MAC_ADDR, LOCAL_IP};
`ifdef W5500_VERSION_CHECK_EN
    localparam logic [31:0] VER_FRAME = {16'h0039, 5'd0, 1'b0, 2'b00, 8'h00};
`endif

    typedef enum logic [2:0] {
        RST_HOLD, RST_WAIT, INIT_XFER, INIT_NEXT, IDLE, XFER
`ifdef W5500_VERSION_CHECK_EN
        , VER_CHK, ERR
`endif
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [DIV_W-1:0]   r_div, w_div_nxt;
    logic [HP_W-1:0]    r_hp, w_hp_nxt;
    logic [31:0]        r_tx, w_tx_nxt;
    logic [7:0]         r_rx, w_rx_nxt;
    logic               r_is_rd, w_is_rd_nxt;
    logic               r_cs, w_cs_nxt;
    logic               r_dclk, w_dclk_nxt;
    logic               r_mosi, w_mosi_nxt;
    logic               r_w5500_rst, w_w5500_rst_nxt;
    logic               r_ready, w_ready_nxt;
    logic               r_rd_valid, w_rd_valid_nxt;
    logic [7:0]         r_rd_data, w_rd_data_nxt;
    logic               r_init_done, w_init_done_nxt;
`ifdef W5500_VERSION_CHECK_EN
    logic               r_init_err, w_init_err_nxt;
`endif
    logic               w_in_xfer, w_tick, w_done, w_start;
    logic [31:0]        w_frame;

    // Init table entry: {addr, control (write, VDM), data}
    function automatic logic [31:0] init_frame(input logic [IDX_W-1:0] idx);
        logic [15:0] addr;
        logic [4:0]  bsb;
        logic [7:0]  data;
        addr = '0;
        bsb  = '0;
        data = '0;
        if (idx < IDX_W'(NET_BYTES)) begin
            addr = 16'(idx) + 16'd1;
            data = 8'(NET_ID >> ((NET_BYTES - 1 - 32'(idx)) * 8));
        end else begin
            bsb = 5'd1;
            case (idx)
                5'd18:   begin addr = 16'h0000; data = 8'h02;           end
                5'd19:   begin addr = 16'h0004; data = SRC_PORT[15:8];  end
                5'd20:   begin addr = 16'h0005; data = SRC_PORT[7:0];   end
                default: begin addr = 16'h0001; data = 8'h01;           end
            endcase
        end
        return {addr, bsb, 1'b1, 2'b00, data};
    endfunction

    // Next-state, serial engine and registered-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_div_nxt       = r_div;
        w_hp_nxt        = r_hp;
        w_tx_nxt        = r_tx;
        w_rx_nxt        = r_rx;
        w_is_rd_nxt     = r_is_rd;
        w_cs_nxt        = r_cs;
        w_dclk_nxt      = r_dclk;
        w_mosi_nxt      = r_mosi;
        w_w5500_rst_nxt = r_w5500_rst;
        w_ready_nxt     = r_ready;
        w_rd_valid_nxt  = 1'b0;
        w_rd_data_nxt   = r_rd_data;
        w_init_done_nxt = r_init_done;
`ifdef W5500_VERSION_CHECK_EN
        w_init_err_nxt  = r_init_err;
`endif
        w_done  = 1'b0;
        w_start = 1'b0;
        w_frame = '0;
        w_tick  = (r_div == '0);

        w_in_xfer = (r_state == INIT_XFER) || (r_state == XFER);
`ifdef W5500_VERSION_CHECK_EN
        if (r_state == VER_CHK) w_in_xfer = 1'b1;
`endif

        // Half-period sequencer: hp 0..63 are SCLK edges, 64 raises CS, 65..66 CS-high gap
        if (w_in_xfer) begin
            if (!w_tick) begin
                w_div_nxt = r_div - DIV_W'(1);
            end else begin
                w_div_nxt = DIV_W'(CLK_DIV - 1);
                w_hp_nxt  = r_hp + HP_W'(1);
                if (r_hp < HP_W'(64)) begin
                    if (!r_hp[0]) begin
                        w_dclk_nxt = 1'b1;
                        w_rx_nxt   = {r_rx[6:0], i_spi_miso};
                    end else begin
                        w_dclk_nxt = 1'b0;
                        w_tx_nxt   = r_tx << 1;
                        w_mosi_nxt = r_tx[30];
                    end
                end else if (r_hp == HP_W'(64)) begin
                    w_cs_nxt = 1'b1;
                    if ((r_state == XFER) && r_is_rd) begin
                        w_rd_valid_nxt = 1'b1;
                        w_rd_data_nxt  = r_rx;
                    end
                end else if (r_hp == HP_W'(66)) begin
                    w_done = 1'b1;
                end
            end
        end

        case (r_state)
            RST_HOLD: begin
                if (r_cnt == CNT_W'(RST_LOW_CYC - 1)) begin
                    w_cnt_nxt       = '0;
                    w_w5500_rst_nxt = 1'b1;
                    w_state_nxt     = RST_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RST_WAIT: begin
                if (r_cnt == CNT_W'(RST_WAIT_CYC - 1)) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_start     = 1'b1;
                    w_frame     = init_frame('0);
                    w_state_nxt = INIT_XFER;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            INIT_XFER: begin
                if (w_done) w_state_nxt = INIT_NEXT;
            end
            INIT_NEXT: begin
                if (r_idx == IDX_W'(INIT_LEN - 1)) begin
`ifdef W5500_VERSION_CHECK_EN
                    w_start     = 1'b1;
                    w_frame     = VER_FRAME;
                    w_state_nxt = VER_CHK;
`else
                    w_init_done_nxt = 1'b1;
                    w_ready_nxt     = 1'b1;
                    w_state_nxt     = IDLE;
`endif
                end else begin
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_start     = 1'b1;
                    w_frame     = init_frame(r_idx + IDX_W'(1));
                    w_state_nxt = INIT_XFER;
                end
            end
            IDLE: begin
                if (i_cmd_valid && r_ready) begin
                    w_ready_nxt = 1'b0;
                    w_is_rd_nxt = !i_cmd_wr;
                    w_start     = 1'b1;
                    w_frame     = {i_cmd_addr, i_cmd_bsb, i_cmd_wr, 2'b00,
                                   i_cmd_wr ? i_cmd_wdata : 8'h00};
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                if (w_done) begin
                    w_ready_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
`ifdef W5500_VERSION_CHECK_EN
            VER_CHK: begin
                if (w_done) begin
                    if (r_rx == 8'h04) begin
                        w_init_done_nxt = 1'b1;
                        w_ready_nxt     = 1'b1;
                        w_state_nxt     = IDLE;
                    end else begin
                        w_init_err_nxt = 1'b1;
                        w_state_nxt    = ERR;
                    end
                end
            end
            ERR: begin
                w_state_nxt = ERR;
            end
`endif
            default: w_state_nxt = RST_HOLD;
        endcase

        // Frame launch: CS falls with the first MOSI bit already valid
        if (w_start) begin
            w_cs_nxt   = 1'b0;
            w_dclk_nxt = 1'b0;
            w_tx_nxt   = w_frame;
            w_mosi_nxt = w_frame[31];
            w_div_nxt  = DIV_W'(CLK_DIV - 1);
            w_hp_nxt   = '0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk_50m) begin
        if (!i_rst_n) begin
            r_state     <= RST_HOLD;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_div       <= '0;
            r_hp        <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_is_rd     <= 1'b0;
            r_cs        <= 1'b1;
            r_dclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_w5500_rst <= 1'b0;
            r_ready     <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_init_done <= 1'b0;
`ifdef W5500_VERSION_CHECK_EN
            r_init_err  <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_div       <= w_div_nxt;
            r_hp        <= w_hp_nxt;
            r_tx        <= w_tx_nxt;
            r_rx        <= w_rx_nxt;
            r_is_rd     <= w_is_rd_nxt;
            r_cs        <= w_cs_nxt;
            r_dclk      <= w_dclk_nxt;
            r_mosi      <= w_mosi_nxt;
            r_w5500_rst <= w_w5500_rst_nxt;
            r_ready     <= w_ready_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
            r_rd_data   <= w_rd_data_nxt;
            r_init_done <= w_init_done_nxt;
`ifdef W5500_VERSION_CHECK_EN
            r_init_err  <= w_init_err_nxt;
`endif
        end
    end

    assign o_spi_cs    = r_cs;
    assign o_spi_dclk  = r_dclk;
    assign o_spi_mosi  = r_mosi;
    assign o_w5500_rst = r_w5500_rst;
    assign o_cmd_ready = r_ready;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_data   = r_rd_data;
    assign o_init_done = r_init_done;
`ifdef W5500_VERSION_CHECK_EN
    assign o_init_err  = r_init_err;
`else
    assign o_init_err  = 1'b0;
`endif

endmodule

// File: tb/tb_w5500_spi_ctrl.sv
// Bench for w5500_spi_ctrl: expected frames/read bytes are queued by the
// stimulus; independent monitors decode SPI frames and read pulses.
module tb_w5500_spi_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_cs, spi_dclk, spi_mosi;
    logic        tb_miso = 1'b0;
    logic        w5500_rst;
    logic        cmd_valid, cmd_wr;
    logic [4:0]  cmd_bsb;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        cmd_ready, rd_valid, init_done, init_err;
    logic [7:0]  rd_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_frames [$];
    logic [7:0]  exp_rd [$];
    logic [7:0]  miso_byte = 8'h00;
    bit          skip_frame = 1'b0;

    // Hand-decoded init frames {addr, control, data}
    logic [31:0] init_exp [22] = '{
        32'h000104C0, 32'h000204A8, 32'h00030400, 32'h00040401,
        32'h000504FF, 32'h000604FF, 32'h000704FF, 32'h00080400,
        32'h00090400, 32'h000A0408, 32'h000B04DC, 32'h000C0401,
        32'h000D0402, 32'h000E0403,
        32'h000F04C0, 32'h001004A8, 32'h00110400, 32'h0012040A,
        32'h00000C02, 32'h00040C08, 32'h00050C40, 32'h00010C01
    };

    always #10 clk = ~clk;

    w5500_spi_ctrl #(
        .CLK_DIV      (2),
        .RST_LOW_CYC  (10),
        .RST_WAIT_CYC (20)
    ) dut (
        .i_clk_50m   (clk),
        .i_rst_n     (rst_n),
        .o_spi_cs    (spi_cs),
        .o_spi_dclk  (spi_dclk),
        .o_spi_mosi  (spi_mosi),
        .i_spi_miso  (tb_miso),
        .o_w5500_rst (w5500_rst),
        .i_cmd_valid (cmd_valid),
        .i_cmd_wr    (cmd_wr),
        .i_cmd_bsb   (cmd_bsb),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_wdata (cmd_wdata),
        .o_cmd_ready (cmd_ready),
        .o_rd_valid  (rd_valid),
        .o_rd_data   (rd_data),
        .o_init_done (init_done),
        .o_init_err  (init_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // SPI frame decoder: MOSI captured on SCLK rising edges until CS rises
    always begin : frame_mon
        logic [31:0] sh;
        int          bits;
        time         t_last, p, p_min, p_max;
        @(negedge spi_cs);
        sh = '0; bits = 0; t_last = 0; p_min = 0; p_max = 0;
        while (1) begin
            @(posedge spi_dclk or posedge spi_cs);
            if (spi_cs) break;
            if (bits >= 1) begin
                p = $time - t_last;
                if (bits == 1) begin
                    p_min = p;
                    p_max = p;
                end else begin
                    if (p < p_min) p_min = p;
                    if (p > p_max) p_max = p;
                end
            end
            t_last = $time;
            sh = {sh[30:0], spi_mosi};
            bits++;
        end
        if (skip_frame) begin
            skip_frame = 1'b0;
            if (exp_frames.size() > 0) void'(exp_frames.pop_front());
        end else if (exp_frames.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_unexpected: got 0x%08h, required none", sh);
        end else begin
            check("frame", sh, exp_frames.pop_front());
            check("frame_rising_edges", 32'(bits), 32'd32);
            check("sclk_period_min", 32'(p_min), 32'd80);
            check("sclk_period_max", 32'(p_max), 32'd80);
        end
    end

    // W5500 MISO model: shifts miso_byte out during the data byte
    always begin : miso_model
        int sb;
        @(negedge spi_cs);
        sb = 0;
        tb_miso = 1'b0;
        while (1) begin
            @(spi_dclk or posedge spi_cs);
            if (spi_cs) break;
            if (spi_dclk) sb++;
            else if (sb >= 24 && sb < 32) tb_miso = miso_byte[31 - sb];
        end
        tb_miso = 1'b0;
    end

    // Read-data monitor
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_rd.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_unexpected: got 0x%02h, required none", rd_data);
            end else begin
                check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
            end
            check("rd_with_cs_high", 32'(spi_cs), 32'd1);
            @(negedge clk);
            check("rd_pulse_width", 32'(rd_valid), 32'd0);
        end
    end

    task automatic check_reset_values();
        check("rst_cs", 32'(spi_cs), 32'd1);
        check("rst_dclk", 32'(spi_dclk), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        check("rst_w5500_rst", 32'(w5500_rst), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_init_err", 32'(init_err), 32'd0);
    endtask

    task automatic run_init(input logic [7:0] ver, input bit expect_ok);
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        foreach (init_exp[i]) exp_frames.push_back(init_exp[i]);
`ifdef W5500_VERSION_CHECK_EN
        exp_frames.push_back(32'h00390000);
`endif
        miso_byte = ver;
        rst_n = 1'b1;
        n = 0;
        while (w5500_rst == 1'b0 && n < 1000) begin n++; @(negedge clk); end
        check("w5500_rst_low_cycles", 32'(n), 32'd10);
        n = 0;
        while (spi_cs == 1'b1 && n < 1000) begin n++; @(negedge clk); end
        check("cs_high_after_rst_release", 32'(n), 32'd20);
        n = 0;
        while (!init_done && !init_err && n < 20000) begin n++; @(negedge clk); end
        if (expect_ok) begin
            check("init_done", 32'(init_done), 32'd1);
            check("init_err_clear", 32'(init_err), 32'd0);
            check("ready_after_init", 32'(cmd_ready), 32'd1);
        end else begin
            check("init_err", 32'(init_err), 32'd1);
            check("init_done_clear", 32'(init_done), 32'd0);
            repeat (300) @(negedge clk);
            check("err_ready_low", 32'(cmd_ready), 32'd0);
            check("err_cs_high", 32'(spi_cs), 32'd1);
            check("err_sticky", 32'(init_err), 32'd1);
        end
        check("init_frames_left", 32'(exp_frames.size()), 32'd0);
    endtask

    task automatic send_cmd(input bit wr, input logic [4:0] bsb, input logic [15:0] addr,
                            input logic [7:0] wd, input logic [31:0] exp_frame,
                            input logic [7:0] rd_byte, input bit junk);
        int n;
        int lat;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 5000) begin n++; @(negedge clk); end
        if (!cmd_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cmd_ready_timeout: got ready=0 after %0d cycles, required 1", n);
            return;
        end
        if (!wr) begin
            miso_byte = rd_byte;
            exp_rd.push_back(rd_byte);
        end
        exp_frames.push_back(exp_frame);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_bsb = bsb; cmd_addr = addr; cmd_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        check("ready_drop_on_accept", 32'(cmd_ready), 32'd0);
        if (junk) begin
            cmd_wr = 1'b1; cmd_bsb = 5'h02; cmd_addr = 16'hDEAD; cmd_wdata = 8'hEE;
        end else begin
            cmd_valid = 1'b0;
        end
        lat = 0;
        while (spi_cs == 1'b0 && lat < 1000) begin lat++; @(negedge clk); end
        cmd_valid = 1'b0;
        n_cmp++;
        if (lat < 128 || lat > 132) begin
            n_bad++;
            $display("FAIL accept_to_cs_high: got %0d clocks, required 128..132", lat);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!cmd_ready && n < 5000) begin n++; @(negedge clk); end
        repeat (10) @(negedge clk);
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_bsb = '0; cmd_addr = '0; cmd_wdata = '0;

        run_init(8'h04, 1'b1);

        send_cmd(1'b1, 5'd1,  16'h0003, 8'h5A, 32'h00030C5A, 8'h00, 1'b0);
        send_cmd(1'b0, 5'd0,  16'h0039, 8'h00, 32'h00390000, 8'hA5, 1'b0);
        send_cmd(1'b1, 5'h1F, 16'hFFFF, 8'hFF, 32'hFFFFFCFF, 8'h00, 1'b1);
        wait_idle();
        check("rd_data_held", 32'(rd_data), 32'h000000A5);
        send_cmd(1'b0, 5'd3,  16'h1234, 8'h99, 32'h12341800, 8'h3C, 1'b0);
        send_cmd(1'b1, 5'd0,  16'h0000, 8'h00, 32'h00000400, 8'h00, 1'b0);
        wait_idle();
        check("cmd_frames_left", 32'(exp_frames.size()), 32'd0);
        check("rd_left", 32'(exp_rd.size()), 32'd0);

        // Reset in the middle of a write frame
        exp_frames.push_back(32'h00100C77);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_bsb = 5'd1; cmd_addr = 16'h0010; cmd_wdata = 8'h77;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("midframe_cs_low", 32'(spi_cs), 32'd0);
        skip_frame = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_cs_high", 32'(spi_cs), 32'd1);
        check("abort_w5500_rst", 32'(w5500_rst), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd0);
        check("abort_init_done", 32'(init_done), 32'd0);

        run_init(8'h04, 1'b1);
        send_cmd(1'b1, 5'd1, 16'h0003, 8'h5A, 32'h00030C5A, 8'h00, 1'b0);
        wait_idle();

`ifdef W5500_VERSION_CHECK_EN
        run_init(8'h51, 1'b0);
`endif

        repeat (20) @(negedge clk);
        check("final_frames_left", 32'(exp_frames.size()), 32'd0);
        check("final_rd_left", 32'(exp_rd.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
